// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub
// Multi-cycle two's-complement adder/subtractor. Operands are consumed
// DIGIT bits per clock, LSB digit first, through a DIGIT-cell ripple chain
// whose carry is held in a register between digits. The result registers
// (sum, cout, ovf) only change on the edge that completes an operation.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Ripple chain of DIGIT full-adder cells.
    // Returns {carry out of the chain, carry into the top cell, digit sum}.
    function automatic logic [DIGIT+1:0] ripple_digit(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             cin
    );
        logic [DIGIT-1:0] s;
        logic             c;
        logic             c_msb;
        s     = {DIGIT{1'b0}};
        c     = cin;
        c_msb = cin;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb = c;
            s[i]  = x[i] ^ y[i] ^ c;
            c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, c_msb, s};
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   opb_r;
    logic [WIDTH-1:0]   psum_r;
    logic               carry_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;

    logic [DIGIT+1:0]       chain_s;
    logic [DIGIT-1:0]       dsum_s;
    logic                   c_msb_s;
    logic                   c_out_s;
    logic [WIDTH+DIGIT-1:0] psum_cat_s;
    logic [WIDTH-1:0]       psum_next_s;

    // Operands shift right each digit so the active digit is always at the
    // bottom; the digit sum enters the partial sum from the top, so after N
    // digits every result digit sits at its own position.
    always_comb begin
        chain_s     = ripple_digit(opa_r[DIGIT-1:0], opb_r[DIGIT-1:0], carry_r);
        dsum_s      = chain_s[DIGIT-1:0];
        c_msb_s     = chain_s[DIGIT];
        c_out_s     = chain_s[DIGIT+1];
        psum_cat_s  = {dsum_s, psum_r};
        psum_next_s = psum_cat_s[WIDTH+DIGIT-1:DIGIT];
    end

    // Control FSM, digit datapath and registered result/handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            psum_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b, seed carry with 1.
                        opa_r   <= a;
                        opb_r   <= b ^ {WIDTH{sub}};
                        carry_r <= sub;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                RUN: begin
                    opa_r   <= opa_r >> DIGIT;
                    opb_r   <= opb_r >> DIGIT;
                    psum_r  <= psum_next_s;
                    carry_r <= c_out_s;
                    if (cnt_r == LAST_CNT) begin
                        cnt_r   <= {CW{1'b0}};
                        sum_r   <= psum_next_s;
                        cout_r  <= c_out_s;
                        ovf_r   <= c_msb_s ^ c_out_s;
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed testbench for digit_serial_addsub (WIDTH=16, DIGIT=4, N=4).
module tb_digit_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int errors;
    int checks;

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operation, let it be accepted, then count cycles to done
    // (bounded). Leaves time at #1 after the edge that raised done.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic ts, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; sub = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy=%b done=%b exp=0/0", busy, done); end
    endtask

    task automatic test_add();
        int lat;
        run_op(16'h1234, 16'h4321, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add1_latency got=%0d exp=4", lat); end
        checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL add1_sum got=%h exp=5555", sum); end
        checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL add1_flags cout=%b ovf=%b exp=0/0", cout, ovf); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add1_done_pulse got=%b exp=0", done); end
        checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL add1_hold got=%h exp=5555", sum); end
        run_op(16'hFFFF, 16'h0001, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add2_latency got=%0d exp=4", lat); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL add2_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL add2_flags cout=%b ovf=%b exp=1/0", cout, ovf); end
    endtask

    task automatic test_overflow();
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_latency got=%0d exp=4", lat); end
        checks++; if (sum !== 16'h8000) begin errors++; $display("FAIL ovf_sum got=%h exp=8000", sum); end
        checks++; if (cout !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_flags cout=%b ovf=%b exp=0/1", cout, ovf); end
    endtask

    task automatic test_sub();
        logic [15:0] va [3] = '{16'h0005, 16'h8000, 16'h1234};
        logic [15:0] vb [3] = '{16'h0007, 16'h0001, 16'h1234};
        logic [15:0] es [3] = '{16'hFFFE, 16'h7FFF, 16'h0000};
        logic        ec [3] = '{1'b0, 1'b1, 1'b1};
        logic        eo [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        for (int k = 0; k < 3; k++) begin
            run_op(va[k], vb[k], 1'b1, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL sub%0d_latency got=%0d exp=4", k, lat); end
            checks++; if (sum !== es[k]) begin errors++; $display("FAIL sub%0d_sum got=%h exp=%h", k, sum, es[k]); end
            checks++; if (cout !== ec[k] || ovf !== eo[k]) begin errors++; $display("FAIL sub%0d_flags cout=%b ovf=%b exp=%b/%b", k, cout, ovf, ec[k], eo[k]); end
        end
    endtask

    task automatic test_start_during_run();
        int ndone;
        int at;
        logic [15:0] got;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        // New request while busy: must be ignored.
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got=%b exp=1", busy); end
        ndone = 0; at = -1; got = 16'h0000;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 2) start = 1'b0;
            if (done) begin ndone++; at = c; got = sum; end
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        checks++; if (at !== 4) begin errors++; $display("FAIL ignore_done_cycle got=%0d exp=4", at); end
        checks++; if (got !== 16'h3333) begin errors++; $display("FAIL ignore_sum got=%h exp=3333", got); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        run_op(16'h0010, 16'h0020, 1'b0, lat);
        checks++; if (sum !== 16'h0030 || lat !== 4) begin errors++; $display("FAIL b2b_first sum=%h lat=%0d exp=0030/4", sum, lat); end
        // Still inside the done cycle: issue the next request.
        a = 16'h0100; b = 16'h0001; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept busy=%b done=%b exp=1/0", busy, done); end
        gap = 1;
        while (!done && gap < 20) begin
            @(posedge clk); #1;
            gap++;
        end
        checks++; if (gap !== 5) begin errors++; $display("FAIL b2b_gap got=%0d exp=5", gap); end
        checks++; if (sum !== 16'h00FF) begin errors++; $display("FAIL b2b_sum got=%h exp=00ff", sum); end
        checks++; if (cout !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL b2b_flags cout=%b ovf=%b exp=1/0", cout, ovf); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        int lat;
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", ndone); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL abort_outputs sum=%h cout=%b ovf=%b exp=0000/0/0", sum, cout, ovf); end
        run_op(16'h0001, 16'h0002, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL after_abort_latency got=%0d exp=4", lat); end
        checks++; if (sum !== 16'h0003) begin errors++; $display("FAIL after_abort_sum got=%h exp=0003", sum); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 16'h0000; b = 16'h0000;
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised, multi-cycle two's-complement adder/subtractor built from a chain of DIGIT full-adder cells. It processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, and carries between digits in a register. It produces sum, carry-out and signed overflow behind a start/busy/done handshake. It is the sequential successor to the single-bit full adder, and it is the arithmetic unit for datapaths that trade latency for area.

## Interface
- WIDTH, 16: operand and result width in bits. Must be ≥ 2.
- DIGIT, 4: bits processed per cycle. Must divide WIDTH exactly. DIGIT = WIDTH gives a single-cycle operation.
- Derived: N = WIDTH/DIGIT, the number of digit cycles per operation.
- clk, input, 1: the only clock. All state updates on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- start, input, 1: request a new operation. Sampled only when busy = 0.
- sub, input, 1: mode select, 0 = a + b, 1 = a − b. Latched with start.
- a, input, WIDTH: first operand. Latched with start.
- b, input, WIDTH: second operand. Latched with start.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse marking that the result registers were just updated.
- sum, output, WIDTH: result (a + b or a − b, modulo 2^WIDTH).
- cout, output, 1: carry out of the MSB. In subtract mode, 1 = no borrow.
- ovf, output, 1: signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB.

## Operation
- States:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1.
  - DONE: busy = 0, done = 1. Lasts exactly one cycle.
- Accepting a request:
  - IDLE or DONE with start = 1: latch a, plus b XOR {WIDTH{sub}}. Set carry register = sub. Set digit counter = 0. Go to RUN.
  - IDLE with start = 0: stay in IDLE.
  - DONE with start = 0: go to IDLE.
- RUN, each cycle:
  - Add digit [counter*DIGIT +: DIGIT] of both latched operands plus the carry register through the DIGIT-cell ripple chain.
  - Store the DIGIT result bits into the internal partial-sum register at the same position.
  - Store the chain carry-out into the carry register.
  - Increment the counter.
- Last digit (counter = N−1):
  - Write the full partial sum to sum.
  - Write the chain carry-out to cout.
  - Write the MSB cell's carry-in XOR carry-out to ovf.
  - Go to DONE.
- sum, cout and ovf change only on that completion edge. They hold their values through IDLE, and through any following RUN, until the next completion.
- start while busy = 1 is ignored. No queuing and no error flag.
- a, b and sub are don't-care except in the cycle where start is accepted.
- Width rules:
  - The counter is ceil(log2(N)) bits, minimum 1.
  - The carry register is 1 bit.
  - No sign extension is performed. Results wrap modulo 2^WIDTH.

## Timing
- Reset (rst_n = 0 at an edge) forces state = IDLE, busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, counter = 0, and carry register = 0.
- Reset has priority over everything, including during RUN. An aborted operation leaves no result and produces no done pulse.
- Latency:
  - start is accepted at edge E0.
  - busy = 1 after E0.
  - The digits are computed on edges E1 … EN.
  - After EN: busy = 0, done = 1, and the result is valid.
  - done is visible N cycles after the accepting edge. Example: N = 4 gives 4 cycles.
- Throughput: start asserted during the done cycle is accepted. Back-to-back operations therefore issue every N+1 cycles.
- N = 1: RUN lasts one cycle, and done follows the accepting edge by 1 cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
All scenarios use WIDTH = 16, DIGIT = 4, so N = 4.

- Reset: hold rst_n = 0 for 2 edges with start = 1 and random operands → busy = 0, done = 0, sum = 0x0000, cout = 0, ovf = 0.
- Add: a = 0x1234, b = 0x4321, sub = 0, pulse start → done exactly 4 cycles after acceptance, sum = 0x5555, cout = 0, ovf = 0. Then a = 0xFFFF, b = 0x0001 → sum = 0x0000, cout = 1, ovf = 0.
- Signed overflow: a = 0x7FFF + b = 0x0001 → sum = 0x8000, cout = 0, ovf = 1.
- Subtract:
  - 0x0005 − 0x0007 → sum = 0xFFFE, cout = 0, ovf = 0.
  - 0x8000 − 0x0001 → sum = 0x7FFF, cout = 1, ovf = 1.
  - 0x1234 − 0x1234 → sum = 0x0000, cout = 1, ovf = 0.
- Handshake:
  - Re-assert start with new operands during RUN → ignored; the result matches the first operands, with a single done pulse.
  - Assert start in the done cycle → accepted; the second done arrives 5 cycles after the first.
- Reset mid-operation: assert rst_n = 0 after 2 RUN cycles, then release → no done pulse, outputs zero. A subsequent 0x0001 + 0x0002 yields sum = 0x0003 after 4 cycles.
